top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning the number of 32-bit memory entries.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have no other ports; the core is self-contained, with unified instruction/data memory.

Function
REQ-006 SHALL be a multicycle RV32I core supporting lw, sw, R-type ALU, I-type ALU, beq and jal; other opcodes return to FETCH.
REQ-007 SHALL index memory array M directly by the byte address value, taken modulo MEM_DEPTH, with one 32-bit word per index and no alignment shift.
  - Example: address 42 reads M[42].
REQ-008 SHALL use a 6-bit FSM state with named constants FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-009 FETCH SHALL latch instr = M[pc] and update pc to pc+4 at the clock edge leaving FETCH.
  - Next state: DECODE.
REQ-010 DECODE SHALL present decoded fields and read register operands.
  - Fields: opcode = instr[6:0], rs1, rd, imm_ext.
  - rs2 = instr[24:20] only for R, S and B formats; rs2 = 0 for all other formats.
  - Register operands rs1/rs2 are latched for the next cycle.
REQ-011 imm_ext SHALL be a sign-extended 32-bit immediate of the correct I/S/B/J format.
  - Example: instr 0xff812083 gives -8.
REQ-012 Load and store SHALL go DECODE -> MEMADR, with alu.a = rs1 value, alu.b = imm_ext, alu.out = a+b (combinational, visible during MEMADR).
REQ-013 Load SHALL go MEMADR -> MEMREAD.
  - In MEMREAD: result = latched ALU output, memory_address = result.
  - Then MEMWB: data = M[memory_address], result = data.
  - Then FETCH: rd is written at the edge entering FETCH.
REQ-014 Store SHALL go MEMADR -> MEMWRITE, writing the rs2 value to M[ALU result], then FETCH.
REQ-015 R-type SHALL go EXECUTER -> ALUWB, and I-type ALU SHALL go EXECUTEI -> ALUWB.
  - Supported operations: add, sub, and, or, xor, slt, sll, srl, sra.
  - ALUWB writes rd, then goes to FETCH.
REQ-016 beq SHALL compare the rs1 and rs2 values in state BEQ and set pc = old_pc + imm_ext when they are equal.
REQ-017 jal SHALL write rd = old_pc+4 and set pc = old_pc + imm_ext, then go to FETCH.
REQ-018 Writes to x0 SHALL be discarded, and x0 SHALL always read 0.
REQ-019 Register file and memory writes SHALL take effect at the rising edge; reads of memory and register file are combinational.

Reset
REQ-020 While reset is high, state SHALL be FETCH and pc_cur SHALL be RESET_PC, asynchronously.
REQ-021 Reset SHALL NOT clear memory M or register file RFMem, so their contents may be preloaded.
REQ-022 Reset asserted mid-instruction SHALL abandon the instruction, with no register or memory write.
REQ-023 The first FETCH after reset deasserts SHALL fetch M[RESET_PC].

Structure
REQ-024 SHALL expose these instance names for hierarchical access:
  - control_fsm, holding current_state and the state constants.
  - fetch, holding pc_cur.
  - instruction_decode, holding rs1, rs2, imm_ext and the sub-instance instanceRegFile with RFMem[0:31].
  - alu, holding a, b and out.
  - memory, holding M.
  - top-level signals opcode, result, memory_address and data.
REQ-025 The opcode constants, ALU-operation enum and FSM state encoding SHALL live in a shared package.
REQ-026 The register file SHALL be its own sub-module, named register_file.

Verification
REQ-027 Preload M[0] = 0x00012083, x2 = 42, M[42] = 0xdeadbeef; release reset.
  - DECODE: opcode = 0000011, rs1 = 2, rs2 = 0, imm_ext = 0.
  - MEMADR: alu.out = 42.
  - MEMREAD: memory_address = 42.
  - MEMWB: data = 0xdeadbeef.
  - Next FETCH: x1 = 0xdeadbeef, pc_cur = 4.
REQ-028 M[4] = 0x00412083, M[46] = 0xcafebabe.
  - DECODE: rs2 = 0, imm_ext = 4.
  - MEMADR: alu.out = 46.
  - Then x1 = 0xcafebabe, pc_cur = 8.
REQ-029 M[8] = 0xff812083, M[34] = 0xbadab00f.
  - imm_ext = -8, alu.b = -8, alu.out = 34.
  - Then x1 = 0xbadab00f, x2 still 42, pc_cur = 12.
REQ-030 Store then load: sw x1,0(x2) followed by lw x3,0(x2) -> x3 equals x1.
REQ-031 beq x0,x0,-8 at pc 8 -> next FETCH at pc 0; bne-equivalent (unequal operands) -> pc 12.
REQ-032 Assert reset during MEMREAD -> state FETCH immediately, rd unchanged, pc_cur = 0.

Source files
------------

// File: rtl/top_pkg.sv
// Shared definitions for the multicycle RV32I core: opcodes, FSM state encoding,
// ALU operations and the decode helpers used by several units.
package top_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [5:0] FETCH    = 6'd0;
    localparam logic [5:0] DECODE   = 6'd1;
    localparam logic [5:0] MEMADR   = 6'd2;
    localparam logic [5:0] MEMREAD  = 6'd3;
    localparam logic [5:0] MEMWB    = 6'd4;
    localparam logic [5:0] MEMWRITE = 6'd5;
    localparam logic [5:0] EXECUTER = 6'd6;
    localparam logic [5:0] EXECUTEI = 6'd7;
    localparam logic [5:0] ALUWB    = 6'd8;
    localparam logic [5:0] BEQ      = 6'd9;
    localparam logic [5:0] JAL      = 6'd10;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_t;

    // funct7[5] selects sub only for R-type; for I-type it only matters on srai.
    function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                           input logic funct7b5,
                                           input logic is_r);
        alu_op_t op;
        case (funct3)
            3'd0:    op = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd4:    op = ALU_XOR;
            3'd5:    op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            3'd7:    op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] instr);
        logic [31:0] imm;
        case (instr[6:0])
            OP_LOAD, OP_I: imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:      imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:     imm = {{19{instr[31]}}, instr[31], instr[7],
                                  instr[30:25], instr[11:8], 1'b0};
            OP_JAL:        imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                  instr[20], instr[30:21], 1'b0};
            default:       imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/top_units.sv
// Building blocks of the multicycle core: register file, control FSM, fetch,
// decode, ALU and the unified word-per-index memory.
module register_file (
    input  logic        clk,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    // Not reset so that contents can be preloaded.
    logic [31:0] RFMem [0:31];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0) RFMem[wa] <= wd;
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : RFMem[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : RFMem[ra2];
endmodule

module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic [5:0] current_state
);
    localparam logic [5:0] FETCH    = top_pkg::FETCH;
    localparam logic [5:0] DECODE   = top_pkg::DECODE;
    localparam logic [5:0] MEMADR   = top_pkg::MEMADR;
    localparam logic [5:0] MEMREAD  = top_pkg::MEMREAD;
    localparam logic [5:0] MEMWB    = top_pkg::MEMWB;
    localparam logic [5:0] MEMWRITE = top_pkg::MEMWRITE;
    localparam logic [5:0] EXECUTER = top_pkg::EXECUTER;
    localparam logic [5:0] EXECUTEI = top_pkg::EXECUTEI;
    localparam logic [5:0] ALUWB    = top_pkg::ALUWB;
    localparam logic [5:0] BEQ      = top_pkg::BEQ;
    localparam logic [5:0] JAL      = top_pkg::JAL;

    logic [5:0] next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) current_state <= FETCH;
        else       current_state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (current_state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (opcode)
                    top_pkg::OP_LOAD,
                    top_pkg::OP_STORE:  next_state = MEMADR;
                    top_pkg::OP_R:      next_state = EXECUTER;
                    top_pkg::OP_I:      next_state = EXECUTEI;
                    top_pkg::OP_BRANCH: next_state = (funct3 == 3'd0) ? BEQ : FETCH;
                    top_pkg::OP_JAL:    next_state = JAL;
                    default:            next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (opcode == top_pkg::OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = FETCH;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BEQ:      next_state = FETCH;
            JAL:      next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end
endmodule

module fetch_unit
    import top_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  state,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] imm_ext,
    input  logic        branch_eq,
    output logic [31:0] pc_cur,
    output logic [31:0] old_pc,
    output logic [31:0] instr
);
    // old_pc keeps the address of the instruction in flight for branch/jump targets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_cur <= RESET_PC;
            old_pc <= RESET_PC;
            instr  <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    instr  <= mem_rdata;
                    old_pc <= pc_cur;
                    pc_cur <= pc_cur + 32'd4;
                end
                BEQ:     if (branch_eq) pc_cur <= old_pc + imm_ext;
                JAL:     pc_cur <= old_pc + imm_ext;
                default: ;
            endcase
        end
    end
endmodule

module decode_unit
    import top_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        latch,
    input  logic        rf_we,
    input  logic [31:0] rf_wd,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm_ext,
    output logic [31:0] a_val,
    output logic [31:0] b_val
);
    logic [31:0] rd1, rd2;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign funct7b5 = instr[30];
    assign rs2      = (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH)
                      ? instr[24:20] : 5'd0;
    assign imm_ext  = imm_gen(instr);

    register_file instanceRegFile (
        .clk (clk),
        .ra1 (rs1),
        .ra2 (rs2),
        .we  (rf_we),
        .wa  (rd),
        .wd  (rf_wd),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_val <= 32'd0;
            b_val <= 32'd0;
        end else if (latch) begin
            a_val <= rd1;
            b_val <= rd2;
        end
    end
endmodule

module alu_unit
    import top_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] out
);
    always_comb begin
        out = 32'd0;
        case (alu_op_t'(op))
            ALU_ADD: out = a + b;
            ALU_SUB: out = a - b;
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_XOR: out = a ^ b;
            ALU_SLT: out = {31'd0, $signed(a) < $signed(b)};
            ALU_SLL: out = a << b[4:0];
            ALU_SRL: out = a >> b[4:0];
            ALU_SRA: out = $unsigned($signed(a) >>> b[4:0]);
            default: out = 32'd0;
        endcase
    end
endmodule

module memory_unit #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(MEM_DEPTH);

    // One word per index: the byte address is used directly, no alignment shift.
    logic [31:0]   M [0:MEM_DEPTH-1];
    logic [AW-1:0] idx;

    assign idx   = AW'(addr % 32'(MEM_DEPTH));
    assign rdata = M[idx];

    always_ff @(posedge clk) begin
        if (we) M[idx] <= wd;
    end
endmodule

// File: rtl/top.sv
// Multicycle RV32I core (lw, sw, R/I ALU, beq, jal) with a unified
// instruction/data memory; control sequencing lives in control_fsm.
module top #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input logic clk,
    input logic reset
);
    import top_pkg::*;

    logic [5:0]  state;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc_cur, old_pc, instr, imm_ext, a_val, b_val;
    logic [31:0] alu_b, alu_out, alu_reg;
    logic [31:0] result, memory_address, data, mem_addr;
    alu_op_t     alu_op;
    logic        rf_we, mem_we;

    control_unit control_fsm (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .current_state (state)
    );

    fetch_unit #(.RESET_PC(RESET_PC)) fetch (
        .clk       (clk),
        .reset     (reset),
        .state     (state),
        .mem_rdata (data),
        .imm_ext   (imm_ext),
        .branch_eq (a_val == b_val),
        .pc_cur    (pc_cur),
        .old_pc    (old_pc),
        .instr     (instr)
    );

    decode_unit instruction_decode (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .latch    (state == DECODE),
        .rf_we    (rf_we),
        .rf_wd    (result),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .imm_ext  (imm_ext),
        .a_val    (a_val),
        .b_val    (b_val)
    );

    assign alu_b  = (state == EXECUTER) ? b_val : imm_ext;
    assign alu_op = (state == EXECUTER || state == EXECUTEI)
                    ? alu_decode(funct3, funct7b5, state == EXECUTER) : ALU_ADD;

    alu_unit alu (
        .a   (a_val),
        .b   (alu_b),
        .op  (alu_op),
        .out (alu_out)
    );

    // ALU result is held only from the states that compute something useful.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) alu_reg <= 32'd0;
        else if (state == MEMADR || state == EXECUTER || state == EXECUTEI)
            alu_reg <= alu_out;
    end

    assign memory_address = alu_reg;
    assign mem_addr       = (state == FETCH) ? pc_cur : memory_address;
    assign mem_we         = (state == MEMWRITE);
    assign rf_we          = (state == MEMWB || state == ALUWB || state == JAL);

    always_comb begin
        result = alu_reg;
        case (state)
            MEMWB:   result = data;
            JAL:     result = old_pc + 32'd4;
            default: result = alu_reg;
        endcase
    end

    memory_unit #(.MEM_DEPTH(MEM_DEPTH)) memory (
        .clk   (clk),
        .addr  (mem_addr),
        .we    (mem_we),
        .wd    (b_val),
        .rdata (data)
    );
endmodule

// File: tb/tb_top.sv
// Directed program run on the multicycle core: loads, store/load, ALU ops,
// jal, taken/not-taken beq, x0 behaviour and reset abandoning a load.
module tb_top;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    top dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_instr(input string tag);
        tick();
        for (int i = 0; i < 12; i++) begin
            if (dut.control_fsm.current_state == top_pkg::FETCH) break;
            tick();
        end
        chk({tag, "_back_to_fetch"}, 32'(dut.control_fsm.current_state), 32'(top_pkg::FETCH));
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 256; i++) dut.memory.M[i] = 32'd0;
        for (int i = 0; i < 32; i++) dut.instruction_decode.instanceRegFile.RFMem[i] = 32'd0;
        dut.instruction_decode.instanceRegFile.RFMem[2] = 32'd42;
        dut.memory.M[0]  = 32'h00012083; // lw   x1,0(x2)
        dut.memory.M[4]  = 32'h00412083; // lw   x1,4(x2)
        dut.memory.M[8]  = 32'hff812083; // lw   x1,-8(x2)
        dut.memory.M[12] = 32'h00112023; // sw   x1,0(x2)
        dut.memory.M[16] = 32'h00012183; // lw   x3,0(x2)
        dut.memory.M[20] = 32'h00210233; // add  x4,x2,x2
        dut.memory.M[24] = 32'h401102b3; // sub  x5,x2,x1
        dut.memory.M[28] = 32'hffd00313; // addi x6,x0,-3
        dut.memory.M[32] = 32'h40135393; // srai x7,x6,1
        dut.memory.M[36] = 32'h00232433; // slt  x8,x6,x2
        dut.memory.M[40] = 32'h00c004ef; // jal  x9,+12
        dut.memory.M[44] = 32'h00100513; // addi x10,x0,1 (skipped)
        dut.memory.M[52] = 32'h00308463; // beq  x1,x3,+8 (taken)
        dut.memory.M[56] = 32'h00200513; // addi x10,x0,2 (skipped)
        dut.memory.M[60] = 32'h00208463; // beq  x1,x2,+8 (not taken)
        dut.memory.M[64] = 32'h00500593; // addi x11,x0,5
        dut.memory.M[68] = 32'h00700013; // addi x0,x0,7
        dut.memory.M[72] = 32'hfe000ce3; // beq  x0,x0,-8
        dut.memory.M[42] = 32'hdeadbeef;
        dut.memory.M[46] = 32'hcafebabe;
        dut.memory.M[34] = 32'hbadab00f;

        tick(); tick();
        chk("reset_state", 32'(dut.control_fsm.current_state), 32'(top_pkg::FETCH));
        chk("reset_pc", dut.fetch.pc_cur, 32'd0);
        reset = 1'b0;

        // lw x1,0(x2)
        tick();
        chk("lw1_opcode", 32'(dut.opcode), 32'h03);
        chk("lw1_rs1", 32'(dut.instruction_decode.rs1), 32'd2);
        chk("lw1_rs2", 32'(dut.instruction_decode.rs2), 32'd0);
        chk("lw1_imm", dut.instruction_decode.imm_ext, 32'd0);
        tick();
        chk("lw1_aluout", dut.alu.out, 32'd42);
        tick();
        chk("lw1_memaddr", dut.memory_address, 32'd42);
        tick();
        chk("lw1_data", dut.data, 32'hdeadbeef);
        tick();
        chk("lw1_state", 32'(dut.control_fsm.current_state), 32'(top_pkg::FETCH));
        chk("lw1_x1", dut.instruction_decode.instanceRegFile.RFMem[1], 32'hdeadbeef);
        chk("lw1_pc", dut.fetch.pc_cur, 32'd4);

        // lw x1,4(x2)
        tick();
        chk("lw2_rs2", 32'(dut.instruction_decode.rs2), 32'd0);
        chk("lw2_imm", dut.instruction_decode.imm_ext, 32'd4);
        tick();
        chk("lw2_aluout", dut.alu.out, 32'd46);
        tick(); tick(); tick();
        chk("lw2_x1", dut.instruction_decode.instanceRegFile.RFMem[1], 32'hcafebabe);
        chk("lw2_pc", dut.fetch.pc_cur, 32'd8);

        // lw x1,-8(x2): negative offset
        tick();
        chk("lw3_imm", dut.instruction_decode.imm_ext, 32'hfffffff8);
        tick();
        chk("lw3_alub", dut.alu.b, 32'hfffffff8);
        chk("lw3_aluout", dut.alu.out, 32'd34);
        tick(); tick(); tick();
        chk("lw3_x1", dut.instruction_decode.instanceRegFile.RFMem[1], 32'hbadab00f);
        chk("lw3_x2", dut.instruction_decode.instanceRegFile.RFMem[2], 32'd42);
        chk("lw3_pc", dut.fetch.pc_cur, 32'd12);

        run_instr("sw");
        chk("sw_mem", dut.memory.M[42], 32'hbadab00f);
        chk("sw_pc", dut.fetch.pc_cur, 32'd16);
        run_instr("lw4");
        chk("lw4_x3", dut.instruction_decode.instanceRegFile.RFMem[3], 32'hbadab00f);
        run_instr("add");
        chk("add_x4", dut.instruction_decode.instanceRegFile.RFMem[4], 32'd84);
        run_instr("sub");
        chk("sub_x5", dut.instruction_decode.instanceRegFile.RFMem[5], 32'h4525501b);
        run_instr("addi");
        chk("addi_x6", dut.instruction_decode.instanceRegFile.RFMem[6], 32'hfffffffd);
        run_instr("srai");
        chk("srai_x7", dut.instruction_decode.instanceRegFile.RFMem[7], 32'hfffffffe);
        run_instr("slt");
        chk("slt_x8", dut.instruction_decode.instanceRegFile.RFMem[8], 32'd1);
        chk("slt_pc", dut.fetch.pc_cur, 32'd40);
        run_instr("jal");
        chk("jal_x9", dut.instruction_decode.instanceRegFile.RFMem[9], 32'd44);
        chk("jal_pc", dut.fetch.pc_cur, 32'd52);
        run_instr("beq_taken");
        chk("beq_taken_pc", dut.fetch.pc_cur, 32'd60);
        run_instr("beq_not_taken");
        chk("beq_not_taken_pc", dut.fetch.pc_cur, 32'd64);
        run_instr("addi_x11");
        chk("addi_x11", dut.instruction_decode.instanceRegFile.RFMem[11], 32'd5);
        chk("skipped_x10", dut.instruction_decode.instanceRegFile.RFMem[10], 32'd0);
        run_instr("addi_x0");
        chk("x0_stays_zero", dut.instruction_decode.instanceRegFile.RFMem[0], 32'd0);
        run_instr("beq_back");
        chk("beq_back_pc", dut.fetch.pc_cur, 32'd64);

        // Reset in the middle of a load must abandon it.
        reset = 1'b1;
        tick();
        chk("reset2_pc", dut.fetch.pc_cur, 32'd0);
        dut.memory.M[42] = 32'h12345678;
        reset = 1'b0;
        tick(); tick(); tick();
        chk("pre_abort_state", 32'(dut.control_fsm.current_state), 32'(top_pkg::MEMREAD));
        #2 reset = 1'b1;
        #1;
        chk("abort_state", 32'(dut.control_fsm.current_state), 32'(top_pkg::FETCH));
        chk("abort_pc", dut.fetch.pc_cur, 32'd0);
        tick(); tick(); tick();
        chk("abort_x1", dut.instruction_decode.instanceRegFile.RFMem[1], 32'hbadab00f);
        reset = 1'b0;
        run_instr("relaunch");
        chk("relaunch_x1", dut.instruction_decode.instanceRegFile.RFMem[1], 32'h12345678);
        chk("relaunch_pc", dut.fetch.pc_cur, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
